rv32i_fetch: RTL and testbench
==============================

// Module: rv32i_fetch
// PURPOSE
//  Instruction-fetch stage that feeds rv32i_decoder. Holds the PC, issues word
//  requests to instruction memory via a strobe/ack handshake, and presents
//  each fetched instruction with its PC and a valid flag to the decode stage.
//  A one-entry skid buffer absorbs downstream stalls. A redirect input serves
//  branches, jumps and traps.
// PARAMETERS
//  PC_RESET  32'h0000_0000  fetch address after reset; bits [1:0] must be 0
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  o_iaddr      out  32  instruction memory word address; [1:0] always 2'b00
//  o_stb_inst   out  1   fetch request; o_iaddr stable while high
//  i_ack_inst   in   1   memory ack; i_inst valid in this cycle
//  i_inst       in   32  instruction word from memory
//  o_inst       out  32  instruction to decoder
//  o_pc         out  32  PC of o_inst
//  o_valid      out  1   o_inst/o_pc hold a live instruction
//  i_stall      in   1   downstream cannot accept; hold o_inst/o_pc/o_valid
//  i_change_pc  in   1   redirect fetch; flushes all fetched state
//  i_new_pc     in   32  redirect target; [1:0] forced to 0
// BEHAVIOUR
//  - Reset (async, rst_n low): state=S_IDLE, pc=PC_RESET, o_iaddr=PC_RESET,
//    o_stb_inst=0, o_inst=0, o_pc=0, o_valid=0, skid empty (data 0).
//  - Transfer: occurs on a rising edge where o_stb_inst && i_ack_inst. That
//    edge captures i_inst with PC = o_iaddr, and sets pc <= pc+4 (mod 2^32;
//    0xFFFF_FFFC wraps to 0). An ack while o_stb_inst=0 is ignored.
//  - o_iaddr, o_stb_inst and all outputs are registered. There is no
//    combinational path from an input to an output.
//  - Consume: on an edge with o_valid && !i_stall, decode takes o_inst.
//  - FSM (o_stb_inst=1 only when the next state is S_FETCH):
//    S_IDLE  : first edge after reset release -> S_FETCH.
//    S_FETCH : on transfer, if the output is free or consumed this edge,
//              o_inst/o_pc <= captured word, o_valid <= 1, stay.
//              On transfer while o_valid && i_stall, the word goes into the
//              skid buffer -> S_FULL (strobe drops at the same edge).
//              With no transfer and a consume, o_valid <= 0.
//    S_FULL  : strobe low. On an edge with !i_stall, output <= skid and
//              skid empties -> S_FETCH.
//    S_REDIR : one bubble cycle with strobe low, so memory drops any pending
//              request -> S_FETCH.
//  - Redirect has priority over everything, in any state. On an edge with
//    i_change_pc: pc and o_iaddr <= {i_new_pc[31:2],2'b00}; o_valid <= 0;
//    skid empty; state -> S_REDIR; o_stb_inst <= 0. An ack on that same edge
//    is discarded, and i_stall is ignored on that edge.
//  - Latency:
//    - Reset release: stb rises after edge 1; with a zero-wait ack, o_valid=1
//      after edge 2 with o_pc=PC_RESET.
//    - Redirect at edge R: first new instruction is valid after edge R+2
//      (zero-wait memory).
//  - Throughput: one instruction per cycle with zero-wait memory and no stall.
//  - Ordering: no instruction is lost, duplicated or reordered across
//    stalls. o_pc always matches o_inst.
//  - Reset asserted mid-request: returns to reset values immediately; the
//    pending request is abandoned.
// TESTING
//  1 Reset: hold rst_n=0, then release with ack tied high -> all outputs 0 and
//    o_iaddr=0 while in reset; o_stb_inst=1 after edge 1; o_valid=1,
//    o_pc=0 after edge 2; then o_pc=4,8,C on successive cycles.
//  2 Wait states: ack every 3rd stb cycle, i_inst=0x00A00093 ->
//    o_iaddr held until ack; o_valid pulses once per ack; o_pc steps by 4.
//  3 Stall: assert i_stall for 4 cycles while streaming -> one extra word
//    enters the skid and o_stb_inst falls; output frozen. On release, the
//    skid word appears next cycle; the sequence is contiguous, no gaps or
//    duplicates.
//  4 Redirect: i_change_pc=1, i_new_pc=0x0000_0103, ack high on the same
//    edge -> that ack is dropped; o_valid=0; one cycle with stb low;
//    o_iaddr=0x100; next valid o_pc=0x100.
//  5 Redirect during stall with skid full -> skid and output flushed;
//    o_valid=0; fetch resumes at i_new_pc despite i_stall=1.
//  6 Wrap: PC_RESET=0xFFFF_FFF8, zero-wait -> o_pc 0xFFFF_FFF8, 0xFFFF_FFFC,
//    0x0000_0000.

Source files
------------

// File: rtl/rv32i_fetch.sv
// RV32I instruction-fetch stage: PC register, strobe/ack memory handshake,
// registered decode-side outputs and a one-entry skid buffer for stalls.
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_change_pc,
    input  logic [31:0] i_new_pc
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_REDIR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        stb_q, stb_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        transfer;

    // pc_q is the address currently presented to memory
    assign transfer = stb_q && i_ack_inst;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        opc_d       = opc_q;
        valid_d     = valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (i_change_pc) begin
            pc_d        = i_new_pc & 32'hFFFF_FFFC;
            valid_d     = 1'b0;
            skid_inst_d = '0;
            skid_pc_d   = '0;
            state_d     = S_REDIR;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: begin
                    if (transfer) begin
                        pc_d = pc_q + 32'd4;
                        if (!valid_q || !i_stall) begin
                            inst_d  = i_inst;
                            opc_d   = pc_q;
                            valid_d = 1'b1;
                        end else begin
                            skid_inst_d = i_inst;
                            skid_pc_d   = pc_q;
                            state_d     = S_FULL;
                        end
                    end else if (valid_q && !i_stall) begin
                        valid_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (!i_stall) begin
                        inst_d      = skid_inst_q;
                        opc_d       = skid_pc_q;
                        valid_d     = 1'b1;
                        skid_inst_d = '0;
                        skid_pc_d   = '0;
                        state_d     = S_FETCH;
                    end
                end
                S_REDIR: state_d = S_FETCH;
                default: state_d = S_IDLE;
            endcase
        end

        stb_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            stb_q       <= 1'b0;
            inst_q      <= '0;
            opc_q       <= '0;
            valid_q     <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stb_q       <= stb_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            valid_q     <= valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign o_iaddr    = pc_q;
    assign o_stb_inst = stb_q;
    assign o_inst     = inst_q;
    assign o_pc       = opc_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: a scoreboard queues every accepted memory
// word with its address and compares it against each instruction consumed.
module tb_rv32i_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] o_iaddr, i_inst, o_inst, o_pc, i_new_pc;
    logic        o_stb_inst, i_ack_inst, o_valid, i_stall, i_change_pc;

    logic [31:0] w_iaddr, w_inst, w_pc;
    logic        w_stb, w_valid;

    rv32i_fetch #(.PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_iaddr(o_iaddr), .o_stb_inst(o_stb_inst),
        .i_ack_inst(i_ack_inst), .i_inst(i_inst),
        .o_inst(o_inst), .o_pc(o_pc), .o_valid(o_valid),
        .i_stall(i_stall), .i_change_pc(i_change_pc), .i_new_pc(i_new_pc)
    );

    rv32i_fetch #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .o_iaddr(w_iaddr), .o_stb_inst(w_stb),
        .i_ack_inst(1'b1), .i_inst(~w_iaddr),
        .o_inst(w_inst), .o_pc(w_pc), .o_valid(w_valid),
        .i_stall(1'b0), .i_change_pc(1'b0), .i_new_pc(32'h0)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [31:0] held_pc;
    bit          use_const;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return use_const ? 32'h00A0_0093 : ((a * 32'h9E37_79B9) ^ 32'h1357_0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: decide from the pre-edge outputs and inputs what the edge does,
    // update the scoreboard, then advance to 1 time unit past the edge.
    task automatic cycle();
        ent_t e;
        i_inst = memf(o_iaddr);
        if (i_change_pc) begin
            q.delete();
            exp_addr = i_new_pc & 32'hFFFF_FFFC;
        end else begin
            if (o_valid && !i_stall) begin
                if (q.size() == 0) begin
                    check("valid_without_word", {31'd0, o_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pc", o_pc, e.pc);
                    check("inst", o_inst, e.inst);
                end
            end
            if (o_stb_inst && i_ack_inst) begin
                check("iaddr", o_iaddr, exp_addr);
                q.push_back('{exp_addr, i_inst});
                exp_addr += 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_ack_inst = 1'b1; i_stall = 1'b0;
        i_change_pc = 1'b0; i_new_pc = '0; use_const = 1'b0;
        i_inst = '0; exp_addr = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_iaddr", o_iaddr, 32'h0);
        check("rst_stb", {31'd0, o_stb_inst}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_wrap_iaddr", w_iaddr, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        // Reset release latency and wrap-around
        cycle();
        check("edge1_stb", {31'd0, o_stb_inst}, 32'd1);
        check("edge1_valid", {31'd0, o_valid}, 32'd0);
        cycle();
        check("edge2_valid", {31'd0, o_valid}, 32'd1);
        check("edge2_pc", o_pc, 32'h0);
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        cycle();
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc2", w_pc, 32'h0000_0000);
        check("wrap_inst2", w_inst, 32'hFFFF_FFFF);
        repeat (2) cycle();

        // Wait states: ack only every third cycle
        use_const = 1'b1;
        for (int k = 0; k < 12; k++) begin
            i_ack_inst = (k % 3 == 2);
            cycle();
        end
        use_const = 1'b0;
        i_ack_inst = 1'b1;
        repeat (2) cycle();

        // Stall while streaming: one word lands in the skid
        held_pc = o_pc;
        i_stall = 1'b1;
        cycle();
        check("stall_stb", {31'd0, o_stb_inst}, 32'd0);
        repeat (3) cycle();
        check("stall_frozen_pc", o_pc, held_pc);
        check("stall_valid", {31'd0, o_valid}, 32'd1);
        i_stall = 1'b0;
        cycle();
        check("skid_pc", o_pc, held_pc + 32'd4);
        repeat (4) cycle();

        // Redirect with a simultaneous ack
        i_change_pc = 1'b1; i_new_pc = 32'h0000_0103;
        cycle();
        i_change_pc = 1'b0;
        check("redir_valid", {31'd0, o_valid}, 32'd0);
        check("redir_stb", {31'd0, o_stb_inst}, 32'd0);
        check("redir_iaddr", o_iaddr, 32'h0000_0100);
        cycle();
        check("redir_stb_back", {31'd0, o_stb_inst}, 32'd1);
        cycle();
        check("redir_first_valid", {31'd0, o_valid}, 32'd1);
        check("redir_first_pc", o_pc, 32'h0000_0100);
        repeat (3) cycle();

        // Redirect while stalled with the skid full
        i_stall = 1'b1;
        repeat (2) cycle();
        check("full_stb", {31'd0, o_stb_inst}, 32'd0);
        i_change_pc = 1'b1; i_new_pc = 32'h0000_0200;
        cycle();
        i_change_pc = 1'b0;
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        check("flush_iaddr", o_iaddr, 32'h0000_0200);
        repeat (2) cycle();
        check("stalled_refetch_valid", {31'd0, o_valid}, 32'd1);
        check("stalled_refetch_pc", o_pc, 32'h0000_0200);
        cycle();
        i_stall = 1'b0;
        repeat (5) cycle();

        // Reset asserted mid-request takes effect without a clock edge
        check("pre_reset_stb", {31'd0, o_stb_inst}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stb", {31'd0, o_stb_inst}, 32'd0);
        check("async_rst_valid", {31'd0, o_valid}, 32'd0);
        check("async_rst_iaddr", o_iaddr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
